csr_register_file: RTL and testbench

CSR_REGISTER_FILE -- requirements
Module: csr_register_file

---
 rtl/csr_register_file_pkg.sv | 48 ++++
 rtl/csr_counter64.sv | 24 ++
 rtl/csr_register_file.sv | 155 +++++++++++++++
 tb/tb_csr_register_file.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_register_file_pkg.sv
// Shared machine-mode CSR definitions: addresses, mstatus bit positions,
// XLEN width codes and synchronous exception codes.
package csr_register_file_pkg;

  localparam logic [1:0] XLEN_32B = 2'd1;
  localparam logic [1:0] XLEN_64B = 2'd2;

  localparam logic [25:0] SUPPORTED_EXTENSIONS_DEFAULT = 26'h000_1104;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  typedef enum logic [3:0] {
    EXC_INSTR_MISALIGNED = 4'd0,
    EXC_INSTR_FAULT      = 4'd1,
    EXC_ILLEGAL_INSTR    = 4'd2,
    EXC_BREAKPOINT       = 4'd3,
    EXC_LOAD_MISALIGNED  = 4'd4,
    EXC_LOAD_FAULT       = 4'd5,
    EXC_STORE_MISALIGNED = 4'd6,
    EXC_STORE_FAULT      = 4'd7,
    EXC_ECALL_M          = 4'd11
  } exc_code_e;

  function automatic logic [1:0] mxl_for(input logic [1:0] xlen);
    return (xlen == XLEN_32B) ? 2'b01 : 2'b10;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit event counter with increment enable and independently writable
// halves; a write to either half takes precedence over the increment.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        we_lo,
  input  logic        we_hi,
  input  logic [31:0] wdata_lo,
  input  logic [31:0] wdata_hi,
  output logic [63:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (we_lo || we_hi) begin
      count <= {we_hi ? wdata_hi : count[63:32], we_lo ? wdata_lo : count[31:0]};
    end else if (inc) begin
      count <= count + 64'd1;
    end
  end

endmodule

// File: rtl/csr_register_file.sv
// Machine-mode CSR register file: combinational read port, masked write
// commit, trap entry / MRET state updates and the cycle/instret counters.
module csr_register_file
  import csr_register_file_pkg::*;
#(
  parameter logic [1:0]  XLEN                 = XLEN_64B,
  parameter logic [25:0] SUPPORTED_EXTENSIONS = SUPPORTED_EXTENSIONS_DEFAULT,
  localparam int         W                    = 1 << (int'(XLEN) + 4)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [11:0]  i_csr_addr,
  input  logic         i_csr_we,
  input  logic [W-1:0] i_csr_wdata,
  input  logic         i_trap_valid,
  input  logic [W-2:0] i_trap_cause,
  input  logic [W-1:0] i_trap_pc,
  input  logic [W-1:0] i_trap_tval,
  input  logic         i_mret,
  input  logic         i_instret,
  output logic [W-1:0] o_csr_rdata,
  output logic         o_csr_illegal,
  output logic [W-1:0] o_trap_target,
  output logic [W-1:0] o_mepc,
  output logic         o_mstatus_mie
);

  localparam bit IS32 = (XLEN == XLEN_32B);

  logic         mie_en;
  logic         mpie;
  logic [1:0]   mpp;
  logic [W-1:0] mie_csr;
  logic [W-1:0] mtvec;
  logic [W-1:0] mscratch;
  logic [W-1:0] mepc;
  logic [W-1:0] mcause;
  logic [W-1:0] mtval;
  logic [63:0]  mcycle;
  logic [63:0]  minstret;
  logic [63:0]  wdata64;
  logic [31:0]  wdata_hi;
  logic         implemented;
  logic         ro_space;
  logic         csr_wr;

  assign ro_space = (i_csr_addr[11:10] == 2'b11);
  // Lower-priority events are dropped whole when a trap or MRET retires.
  assign csr_wr   = i_csr_we && implemented && !ro_space && !i_trap_valid && !i_mret;
  assign wdata64  = 64'(i_csr_wdata);
  assign wdata_hi = IS32 ? wdata64[31:0] : wdata64[63:32];

  always_comb begin
    o_csr_rdata = '0;
    implemented = 1'b1;
    case (i_csr_addr)
      CSR_MSTATUS: begin
        o_csr_rdata[MSTATUS_MIE]                   = mie_en;
        o_csr_rdata[MSTATUS_MPIE]                  = mpie;
        o_csr_rdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = mpp;
      end
      CSR_MISA: begin
        o_csr_rdata[W-1:W-2] = mxl_for(XLEN);
        o_csr_rdata[25:0]    = SUPPORTED_EXTENSIONS;
      end
      CSR_MIE:       o_csr_rdata = mie_csr;
      CSR_MTVEC:     o_csr_rdata = mtvec;
      CSR_MSCRATCH:  o_csr_rdata = mscratch;
      CSR_MEPC:      o_csr_rdata = mepc;
      CSR_MCAUSE:    o_csr_rdata = mcause;
      CSR_MTVAL:     o_csr_rdata = mtval;
      CSR_MCYCLE:    o_csr_rdata = mcycle[W-1:0];
      CSR_MINSTRET:  o_csr_rdata = minstret[W-1:0];
      CSR_MCYCLEH: begin
        if (IS32) o_csr_rdata = W'(mcycle[63:32]);
        else      implemented = 1'b0;
      end
      CSR_MINSTRETH: begin
        if (IS32) o_csr_rdata = W'(minstret[63:32]);
        else      implemented = 1'b0;
      end
      CSR_MHARTID, CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: o_csr_rdata = '0;
      default:       implemented = 1'b0;
    endcase
  end

  assign o_csr_illegal = !implemented || (i_csr_we && ro_space);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mie_en   <= 1'b0;
      mpie     <= 1'b0;
      mpp      <= 2'b11;
      mie_csr  <= '0;
      mtvec    <= '0;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
      mtval    <= '0;
    end else if (i_trap_valid) begin
      mepc   <= {i_trap_pc[W-1:1], 1'b0};
      mcause <= {1'b0, i_trap_cause};
      mtval  <= i_trap_tval;
      mpie   <= mie_en;
      mie_en <= 1'b0;
      mpp    <= 2'b11;
    end else if (i_mret) begin
      mie_en <= mpie;
      mpie   <= 1'b1;
      mpp    <= 2'b11;
    end else if (csr_wr) begin
      case (i_csr_addr)
        CSR_MSTATUS: begin
          mie_en <= i_csr_wdata[MSTATUS_MIE];
          mpie   <= i_csr_wdata[MSTATUS_MPIE];
          mpp    <= i_csr_wdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
        end
        CSR_MIE:      mie_csr  <= i_csr_wdata;
        CSR_MTVEC:    mtvec    <= i_csr_wdata;
        CSR_MSCRATCH: mscratch <= i_csr_wdata;
        CSR_MEPC:     mepc     <= {i_csr_wdata[W-1:1], 1'b0};
        CSR_MCAUSE:   mcause   <= i_csr_wdata;
        CSR_MTVAL:    mtval    <= i_csr_wdata;
        default: ;
      endcase
    end
  end

  csr_counter64 u_mcycle (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .inc      (1'b1),
    .we_lo    (csr_wr && (i_csr_addr == CSR_MCYCLE)),
    .we_hi    (csr_wr && (i_csr_addr == (IS32 ? CSR_MCYCLEH : CSR_MCYCLE))),
    .wdata_lo (wdata64[31:0]),
    .wdata_hi (wdata_hi),
    .count    (mcycle)
  );

  csr_counter64 u_minstret (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .inc      (i_instret),
    .we_lo    (csr_wr && (i_csr_addr == CSR_MINSTRET)),
    .we_hi    (csr_wr && (i_csr_addr == (IS32 ? CSR_MINSTRETH : CSR_MINSTRET))),
    .wdata_lo (wdata64[31:0]),
    .wdata_hi (wdata_hi),
    .count    (minstret)
  );

  assign o_trap_target = {mtvec[W-1:2], 2'b00};
  assign o_mepc        = mepc;
  assign o_mstatus_mie = mie_en;

endmodule

// File: tb/tb_csr_register_file.sv
// Directed self-checking bench for csr_register_file at the default XLEN=64.
module tb_csr_register_file;
  import csr_register_file_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [11:0] addr;
  logic        we;
  logic [63:0] wdata;
  logic        trap_valid;
  logic [62:0] trap_cause;
  logic [63:0] trap_pc;
  logic [63:0] trap_tval;
  logic        mret;
  logic        instret;
  logic [63:0] rdata;
  logic        illegal;
  logic [63:0] trap_target;
  logic [63:0] mepc_out;
  logic        mstatus_mie;

  int checks   = 0;
  int failures = 0;

  localparam logic [63:0] MISA_EXP = 64'h8000_0000_0000_1104;

  csr_register_file dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_csr_addr    (addr),
    .i_csr_we      (we),
    .i_csr_wdata   (wdata),
    .i_trap_valid  (trap_valid),
    .i_trap_cause  (trap_cause),
    .i_trap_pc     (trap_pc),
    .i_trap_tval   (trap_tval),
    .i_mret        (mret),
    .i_instret     (instret),
    .o_csr_rdata   (rdata),
    .o_csr_illegal (illegal),
    .o_trap_target (trap_target),
    .o_mepc        (mepc_out),
    .o_mstatus_mie (mstatus_mie)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; addr = CSR_MSTATUS; we = 1'b0; wdata = '0;
    trap_valid = 1'b0; trap_cause = '0; trap_pc = '0; trap_tval = '0;
    mret = 1'b0; instret = 1'b0;
    #12;
    checks++;
    if (rdata !== 64'h1800) begin
      failures++; $display("[TB] FAIL reset_mstatus: got %h expected %h", rdata, 64'h1800);
    end
    checks++;
    if ({trap_target, mepc_out, mstatus_mie} !== {64'd0, 64'd0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got target=%h mepc=%h mie=%b expected 0/0/0", trap_target, mepc_out, mstatus_mie);
    end
    rst_n = 1'b1;
    addr = CSR_MCYCLE;
    #1;
    checks++;
    if (rdata !== 64'd0) begin
      failures++; $display("[TB] FAIL reset_mcycle: got %h expected 0", rdata);
    end
    cycle();
    checks++;
    if (rdata !== 64'd1) begin
      failures++; $display("[TB] FAIL first_increment: got %h expected 1", rdata);
    end
  endtask

  task automatic test_misa();
    addr = CSR_MISA;
    #1;
    checks++;
    if ({rdata, illegal} !== {MISA_EXP, 1'b0}) begin
      failures++; $display("[TB] FAIL misa_read: got %h illegal=%b expected %h illegal=0", rdata, illegal, MISA_EXP);
    end
    we = 1'b1; wdata = '0;
    cycle();
    we = 1'b0;
    #1;
    checks++;
    if (rdata !== MISA_EXP) begin
      failures++; $display("[TB] FAIL misa_readonly: got %h expected %h", rdata, MISA_EXP);
    end
  endtask

  task automatic test_mscratch();
    addr = CSR_MSCRATCH; we = 1'b1; wdata = 64'hDEAD_BEEF;
    cycle();
    we = 1'b0;
    #1;
    checks++;
    if (rdata !== 64'hDEAD_BEEF) begin
      failures++; $display("[TB] FAIL mscratch_rw: got %h expected %h", rdata, 64'hDEAD_BEEF);
    end
    addr = CSR_MHARTID; we = 1'b1; wdata = 64'h1234;
    #1;
    checks++;
    if (illegal !== 1'b1) begin
      failures++; $display("[TB] FAIL ro_write_illegal: got %b expected 1", illegal);
    end
    cycle();
    we = 1'b0;
    #1;
    checks++;
    if ({rdata, illegal} !== {64'd0, 1'b0}) begin
      failures++; $display("[TB] FAIL mhartid_read: got %h illegal=%b expected 0 illegal=0", rdata, illegal);
    end
  endtask

  task automatic test_illegal_read();
    addr = 12'h7C0;
    #1;
    checks++;
    if ({rdata, illegal} !== {64'd0, 1'b1}) begin
      failures++; $display("[TB] FAIL unimpl_read: got %h illegal=%b expected 0 illegal=1", rdata, illegal);
    end
    addr = CSR_MCYCLEH;
    #1;
    checks++;
    if ({rdata, illegal} !== {64'd0, 1'b1}) begin
      failures++; $display("[TB] FAIL mcycleh_rv64: got %h illegal=%b expected 0 illegal=1", rdata, illegal);
    end
    addr = CSR_MVENDORID;
    #1;
    checks++;
    if ({rdata, illegal} !== {64'd0, 1'b0}) begin
      failures++; $display("[TB] FAIL mvendorid_read: got %h illegal=%b expected 0 illegal=0", rdata, illegal);
    end
  endtask

  task automatic test_trap_mret();
    addr = CSR_MTVEC; we = 1'b1; wdata = 64'h1003;
    cycle();
    addr = CSR_MSTATUS; wdata = 64'h1808;
    cycle();
    we = 1'b0;
    checks++;
    if ({trap_target, mstatus_mie} !== {64'h1000, 1'b1}) begin
      failures++; $display("[TB] FAIL mtvec_mie_setup: got target=%h mie=%b expected 1000/1", trap_target, mstatus_mie);
    end
    trap_valid = 1'b1; trap_cause = 63'(EXC_ILLEGAL_INSTR); trap_pc = 64'h1003; trap_tval = 64'h55;
    cycle();
    trap_valid = 1'b0;
    checks++;
    if ({mepc_out, mstatus_mie} !== {64'h1002, 1'b0}) begin
      failures++; $display("[TB] FAIL trap_mepc_mie: got mepc=%h mie=%b expected 1002/0", mepc_out, mstatus_mie);
    end
    addr = CSR_MCAUSE;
    #1;
    checks++;
    if (rdata !== 64'd2) begin
      failures++; $display("[TB] FAIL trap_mcause: got %h expected 2", rdata);
    end
    addr = CSR_MTVAL;
    #1;
    checks++;
    if (rdata !== 64'h55) begin
      failures++; $display("[TB] FAIL trap_mtval: got %h expected 55", rdata);
    end
    addr = CSR_MSTATUS;
    #1;
    checks++;
    if (rdata !== 64'h1880) begin
      failures++; $display("[TB] FAIL trap_mstatus: got %h expected 1880", rdata);
    end
    mret = 1'b1;
    cycle();
    mret = 1'b0;
    checks++;
    if ({rdata, mstatus_mie} !== {64'h1888, 1'b1}) begin
      failures++; $display("[TB] FAIL mret_mstatus: got %h mie=%b expected 1888/1", rdata, mstatus_mie);
    end
  endtask

  task automatic test_priority();
    trap_valid = 1'b1; trap_pc = 64'h2001; trap_cause = 63'(EXC_ECALL_M); trap_tval = '0;
    addr = CSR_MEPC; we = 1'b1; wdata = 64'h8000;
    cycle();
    trap_valid = 1'b0; we = 1'b0;
    checks++;
    if (mepc_out !== 64'h2000) begin
      failures++; $display("[TB] FAIL trap_beats_mepc_write: got %h expected 2000", mepc_out);
    end
    mret = 1'b1; addr = CSR_MSCRATCH; we = 1'b1; wdata = 64'h1111;
    cycle();
    mret = 1'b0; we = 1'b0;
    checks++;
    if ({rdata, mstatus_mie} !== {64'hDEAD_BEEF, 1'b1}) begin
      failures++; $display("[TB] FAIL mret_beats_write: got %h mie=%b expected deadbeef/1", rdata, mstatus_mie);
    end
    trap_valid = 1'b1; mret = 1'b1; trap_pc = 64'h3000;
    addr = CSR_MSTATUS;
    cycle();
    trap_valid = 1'b0; mret = 1'b0;
    checks++;
    if ({rdata, mepc_out} !== {64'h1880, 64'h3000}) begin
      failures++; $display("[TB] FAIL trap_beats_mret: got mstatus=%h mepc=%h expected 1880/3000", rdata, mepc_out);
    end
  endtask

  task automatic test_counters();
    addr = CSR_MCYCLE; we = 1'b1; wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    cycle();
    we = 1'b0;
    checks++;
    if (rdata !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      failures++; $display("[TB] FAIL mcycle_write: got %h expected all ones", rdata);
    end
    cycle();
    checks++;
    if (rdata !== 64'd0) begin
      failures++; $display("[TB] FAIL mcycle_wrap: got %h expected 0", rdata);
    end
    addr = CSR_MINSTRET; we = 1'b1; wdata = 64'd5; instret = 1'b1;
    cycle();
    we = 1'b0;
    checks++;
    if (rdata !== 64'd6 - 64'd1) begin
      failures++; $display("[TB] FAIL minstret_write_wins: got %h expected 5", rdata);
    end
    cycle();
    cycle();
    cycle();
    instret = 1'b0;
    cycle();
    checks++;
    if (rdata !== 64'd8) begin
      failures++; $display("[TB] FAIL minstret_count: got %h expected 8", rdata);
    end
  endtask

  task automatic test_async_reset();
    addr = CSR_MCYCLE; we = 1'b1; wdata = 64'd100;
    cycle();
    we = 1'b0;
    checks++;
    if (rdata !== 64'd100) begin
      failures++; $display("[TB] FAIL mcycle_100: got %h expected 100", rdata);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rdata !== 64'd0) begin
      failures++; $display("[TB] FAIL async_reset_mcycle: got %h expected 0", rdata);
    end
    #1 rst_n = 1'b1;
    cycle();
    trap_valid = 1'b1; trap_pc = 64'h4000; trap_tval = 64'h77;
    #2 rst_n = 1'b0;
    #1;
    cycle();
    trap_valid = 1'b0;
    addr = CSR_MSTATUS;
    #1;
    checks++;
    if ({mepc_out, rdata, mstatus_mie} !== {64'd0, 64'h1800, 1'b0}) begin
      failures++; $display("[TB] FAIL reset_mid_trap: got mepc=%h mstatus=%h mie=%b expected 0/1800/0", mepc_out, rdata, mstatus_mie);
    end
    rst_n = 1'b1;
    cycle();
  endtask

  initial begin
    test_reset();
    test_misa();
    test_mscratch();
    test_illegal_read();
    test_trap_mret();
    test_priority();
    test_counters();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
